sram_dp_fifo_ctrl: RTL and testbench

SRAM_DP_FIFO_CTRL -- requirements
Module: sram_dp_fifo_ctrl

---
 rtl/sram_dp_fifo_ctrl.sv | 153 +++++++++++++++
 tb/tb_sram_dp_fifo_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_fifo_ctrl.sv
// 64x32 FIFO controller over a 1W/1R synchronous SRAM with a 2-entry show-ahead skid.
// Define SRAM_FIFO_PARITY_EN to store and check per-byte even parity in mem_da[35:32].
module sram_dp_fifo_ctrl #(
    parameter int AF_THRESH = 56
) (
    input  logic        CLKA,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic [6:0]  level,
    output logic        almost_full,
    output logic        parity_err,
    output logic        mem_mea,
    output logic        mem_wea,
    output logic [5:0]  mem_adra,
    output logic [35:0] mem_da,
    output logic        mem_meb,
    output logic        mem_web,
    output logic [5:0]  mem_adrb,
    input  logic [35:0] mem_qb
);

    logic [5:0]  wptr_q, wptr_d;
    logic [5:0]  rptr_q, rptr_d;
    logic [6:0]  level_q, level_d;
    logic [6:0]  mcnt_q, mcnt_d;
    logic [1:0]  skid_cnt_q, skid_cnt_d;
    logic [31:0] skid0_q, skid0_d;
    logic [31:0] skid1_q, skid1_d;
    logic        infl_q, infl_d;
    logic        perr_q, perr_d;

    logic        push;
    logic        pop;
    logic        issue;
    logic [2:0]  occ;
    logic        cap_perr;

    assign wr_ready    = (level_q < 7'd64);
    assign rd_valid    = (skid_cnt_q != 2'd0);
    assign rd_data     = skid0_q;
    assign level       = level_q;
    assign almost_full = (level_q >= 7'(AF_THRESH));
    assign parity_err  = perr_q;

    assign push = reset_n & ~clr & wr_valid & wr_ready;
    assign pop  = ~clr & rd_valid & rd_ready;

    // A slot freed by this cycle's pop may be refilled by a read issued now.
    assign occ   = 3'(skid_cnt_q) + 3'(infl_q);
    assign issue = reset_n & ~clr & (mcnt_q != 7'd0)
                 & (pop ? (occ < 3'd3) : (occ < 3'd2));

    assign mem_mea  = push;
    assign mem_wea  = push;
    assign mem_adra = wptr_q;
    assign mem_meb  = issue;
    assign mem_web  = 1'b0;
    assign mem_adrb = rptr_q;

`ifdef SRAM_FIFO_PARITY_EN
    function automatic logic [3:0] byte_par(input logic [31:0] d);
        byte_par = {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
    endfunction

    assign mem_da   = {byte_par(wr_data), wr_data};
    assign cap_perr = infl_q & (byte_par(mem_qb[31:0]) != mem_qb[35:32]);
`else
    logic unused_qb_par;

    assign mem_da        = {4'b0000, wr_data};
    assign cap_perr      = 1'b0;
    assign unused_qb_par = ^mem_qb[35:32];
`endif

    always_comb begin
        wptr_d  = wptr_q + 6'(push);
        rptr_d  = rptr_q + 6'(issue);
        level_d = level_q + 7'(push) - 7'(pop);
        mcnt_d  = mcnt_q + 7'(push) - 7'(issue);
        infl_d  = issue;
        perr_d  = perr_q | cap_perr;
    end

    always_comb begin
        skid_cnt_d = skid_cnt_q;
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        case ({pop, infl_q})
            2'b10: begin
                skid0_d    = skid1_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b01: begin
                if (skid_cnt_q == 2'd0) begin
                    skid0_d = mem_qb[31:0];
                end else begin
                    skid1_d = mem_qb[31:0];
                end
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid0_d = mem_qb[31:0];
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = mem_qb[31:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLKA or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            mcnt_q     <= '0;
            skid_cnt_q <= '0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            infl_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else if (clr) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            mcnt_q     <= '0;
            skid_cnt_q <= '0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            infl_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            mcnt_q     <= mcnt_d;
            skid_cnt_q <= skid_cnt_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            infl_q     <= infl_d;
            perr_q     <= perr_d;
        end
    end

endmodule

// File: tb/tb_sram_dp_fifo_ctrl.sv
// Scoreboard bench for sram_dp_fifo_ctrl with a behavioural 64x36 SRAM.
// Honours SRAM_FIFO_PARITY_EN when deciding the expected parity_err.
module tb_sram_dp_fifo_ctrl;

    logic        CLKA = 1'b0;
    logic        reset_n = 1'b0;
    logic        clr = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic [6:0]  level;
    logic        almost_full;
    logic        parity_err;
    logic        mem_mea;
    logic        mem_wea;
    logic [5:0]  mem_adra;
    logic [35:0] mem_da;
    logic        mem_meb;
    logic        mem_web;
    logic [5:0]  mem_adrb;
    logic [35:0] mem_qb = '0;

`ifdef SRAM_FIFO_PARITY_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif

    sram_dp_fifo_ctrl #(.AF_THRESH(56)) dut (
        .CLKA(CLKA), .reset_n(reset_n), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level), .almost_full(almost_full), .parity_err(parity_err),
        .mem_mea(mem_mea), .mem_wea(mem_wea), .mem_adra(mem_adra),
        .mem_da(mem_da), .mem_meb(mem_meb), .mem_web(mem_web),
        .mem_adrb(mem_adrb), .mem_qb(mem_qb)
    );

    always #5 CLKA = ~CLKA;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural SRAM; flip_en corrupts bit 5 of any read it overlaps.
    logic [35:0] mem [64];
    logic        flip_en = 1'b0;

    always @(posedge CLKA) begin
        if (mem_mea && mem_wea) mem[mem_adra] <= mem_da;
        if (mem_meb) mem_qb <= mem[mem_adrb] ^ (flip_en ? 36'h20 : 36'h0);
    end

    logic [31:0] sb [$];
    logic [31:0] xor_mask = '0;
    logic        stall_q = 1'b0;
    logic [31:0] stall_data = '0;
    logic [31:0] exp_w;

    always @(negedge CLKA) begin
        if (!reset_n) begin
            sb.delete();
            stall_q = 1'b0;
        end else begin
            check("level", level, sb.size());
            check("wr_ready", wr_ready, sb.size() < 64);
            check("almost_full", almost_full, sb.size() >= 56);
            if (sb.size() == 0) check("empty_rd_valid", rd_valid, 0);
            if (mem_mea && mem_meb) check("port_collide", mem_adra == mem_adrb, 0);
            if (stall_q) begin
                check("stall_valid", rd_valid, 1);
                check("stall_data", rd_data, stall_data);
            end
            if (clr) begin
                sb.delete();
                stall_q = 1'b0;
            end else begin
                if (rd_valid && rd_ready && sb.size() != 0) begin
                    exp_w = sb.pop_front();
                    check("rd_data", rd_data, exp_w);
                end
                if (wr_valid && wr_ready) sb.push_back(wr_data ^ xor_mask);
                stall_q    = rd_valid && !rd_ready;
                stall_data = rd_data;
            end
        end
    end

    task automatic cyc();
        @(posedge CLKA);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        while ((sb.size() != 0 || rd_valid) && n < budget) begin
            cyc();
            n++;
        end
        check("drain_timeout", n < budget, 1);
        rd_ready = 1'b0;
    endtask

    task automatic push_n(input int cnt, input logic [31:0] base);
        for (int i = 0; i < cnt; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            cyc();
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        #22;
        check("rst_mea", mem_mea, 0);
        check("rst_wea", mem_wea, 0);
        check("rst_meb", mem_meb, 0);
        check("rst_web", mem_web, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_level", level, 0);
        check("rst_af", almost_full, 0);
        check("rst_perr", parity_err, 0);
        check("rst_rd_data", rd_data, 0);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        @(posedge CLKA);
        #1 reset_n = 1'b1;
        @(negedge CLKA);
        check("rel_wr_ready", wr_ready, 1);

        // Latency: push at edge N, rd_valid visible after N+2.
        cyc();
        wr_valid = 1'b1;
        wr_data  = 32'hDEADBEEF;
        @(posedge CLKA);
        #1 wr_valid = 1'b0;
        @(negedge CLKA);
        check("lat_n0", rd_valid, 0);
        @(negedge CLKA);
        check("lat_n1", rd_valid, 0);
        @(negedge CLKA);
        check("lat_n2", rd_valid, 1);
        check("lat_data", rd_data, 32'hDEADBEEF);
        cyc();
        drain(20);

        // Fill to 64, refuse the 65th even with a pop, drain in order.
        push_n(64, 32'd0);
        wr_valid = 1'b1;
        wr_data  = 32'h99;
        repeat (3) cyc();
        @(negedge CLKA);
        check("full_wr_ready", wr_ready, 0);
        check("full_level", level, 64);
        check("full_af", almost_full, 1);
        @(posedge CLKA);
        #1 rd_ready = 1'b1;
        @(negedge CLKA);
        check("full_pop_refuse", wr_ready, 0);
        @(posedge CLKA);
        #1 rd_ready = 1'b0;
        wr_valid = 1'b0;
        @(negedge CLKA);
        check("full_after_pop", level, 63);
        cyc();
        drain(200);

        // Streaming with a constant level of 3.
        push_n(3, 32'h1000);
        repeat (4) cyc();
        rd_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            wr_valid = 1'b1;
            wr_data  = $urandom;
            @(negedge CLKA);
            check("tput_pop", rd_valid, 1);
            check("tput_level", level, 3);
            @(posedge CLKA);
            #1;
        end
        drain(40);

        // Random back-pressure and random pushes.
        push_n(3, 32'h2000);
        for (int i = 0; i < 150; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = $urandom;
            rd_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        drain(200);

        // Flush with a read in flight.
        push_n(10, 32'h3000);
        repeat (4) cyc();
        wr_valid = 1'b1;
        wr_data  = 32'h3100;
        rd_ready = 1'b1;
        cyc();
        clr      = 1'b1;
        wr_data  = 32'hBAD;
        @(negedge CLKA);
        check("clr_pre_level", level, 10);
        @(posedge CLKA);
        #1;
        clr      = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        @(negedge CLKA);
        check("clr_level", level, 0);
        check("clr_rd_valid", rd_valid, 0);
        cyc();
        @(negedge CLKA);
        check("clr_no_ghost", rd_valid, 0);
        cyc();
        push_n(1, 32'h1);
        repeat (3) cyc();
        @(negedge CLKA);
        check("clr_next_valid", rd_valid, 1);
        check("clr_next_data", rd_data, 32'h1);
        cyc();
        drain(20);

        // Corrupt bit 5 on one SRAM read.
        flip_en  = 1'b1;
        xor_mask = 32'h20;
        push_n(1, 32'h12345678);
        xor_mask = '0;
        repeat (4) cyc();
        flip_en = 1'b0;
        @(negedge CLKA);
        check("perr_set", parity_err, PE);
        cyc();
        drain(20);
        repeat (3) cyc();
        @(negedge CLKA);
        check("perr_hold", parity_err, PE);
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        @(negedge CLKA);
        check("perr_clr", parity_err, 0);

        // Asynchronous reset in the middle of traffic.
        cyc();
        push_n(5, 32'h4000);
        wr_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("arst_level", level, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_mea", mem_mea, 0);
        check("arst_meb", mem_meb, 0);
        @(posedge CLKA);
        #1 reset_n = 1'b1;
        wr_valid = 1'b0;
        cyc();
        push_n(1, 32'hCAFE);
        repeat (3) cyc();
        @(negedge CLKA);
        check("arst_next_data", rd_data, 32'hCAFE);
        cyc();
        drain(20);

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
